// File: rtl/slave_out_data_ctrl_pkg.sv
// Shared USB constants for the slave controller.
// Holds the PID codes seen or produced by the OUT/SETUP data-phase sequencer,
// the bit positions inside transStatus, and the sequencer state encoding.
package slave_out_data_ctrl_pkg;

   // Token PIDs
   localparam logic [3:0] PID_OUT   = 4'h1;
   localparam logic [3:0] PID_SETUP = 4'hd;
   // Data PIDs
   localparam logic [3:0] PID_DATA0 = 4'h3;
   localparam logic [3:0] PID_DATA1 = 4'hb;
   // Handshake PIDs
   localparam logic [3:0] PID_ACK   = 4'h2;
   localparam logic [3:0] PID_NAK   = 4'ha;
   localparam logic [3:0] PID_STALL = 4'he;

   // transStatus bit positions
   localparam int ST_TIMEOUT = 0;
   localparam int ST_CRC     = 1;
   localparam int ST_ACK     = 2;
   localparam int ST_NAK     = 3;
   localparam int ST_STALL   = 4;
   localparam int ST_DUP     = 5;

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      WAIT_RDY,
      EVAL,
      HS_DELAY,
      SEND_HS,
      DONE
   } ctrlState_t;

endpackage

// File: rtl/slave_out_data_ctrl_if.sv
// Bundle of signals around the OUT/SETUP data-phase sequencer.
//   token decoder : tokenRxed, tokenPID, tokenEndP
//   endpoint cfg  : epEnable, epStall, epReady
//   receiver      : getPacketEn, RXPacketRdy, RxPID, CRCError, bitStuffError,
//                   RXOverflow, RXTimeOut, dataSequence
//   RX FIFO       : fifoCommit, fifoFlush
//   sender        : sendPacketWEn, sendPacketPID, sendPacketRdy
//   status        : dataToggle, transDone, transStatus
// Modport slave is the sequencer's view; master is the surrounding logic.
interface slave_out_data_ctrl_if #(parameter int NUM_EP = 4);

   logic              tokenRxed;
   logic [3:0]        tokenPID;
   logic [1:0]        tokenEndP;
   logic [NUM_EP-1:0] epEnable;
   logic [NUM_EP-1:0] epStall;
   logic [NUM_EP-1:0] epReady;
   logic              getPacketEn;
   logic              RXPacketRdy;
   logic [3:0]        RxPID;
   logic              CRCError;
   logic              bitStuffError;
   logic              RXOverflow;
   logic              RXTimeOut;
   logic              dataSequence;
   logic              fifoCommit;
   logic              fifoFlush;
   logic              sendPacketWEn;
   logic [3:0]        sendPacketPID;
   logic              sendPacketRdy;
   logic [NUM_EP-1:0] dataToggle;
   logic              transDone;
   logic [5:0]        transStatus;

   modport slave (
      input  tokenRxed, tokenPID, tokenEndP, epEnable, epStall, epReady,
      input  RXPacketRdy, RxPID, CRCError, bitStuffError, RXOverflow, RXTimeOut,
      input  dataSequence, sendPacketRdy,
      output getPacketEn, fifoCommit, fifoFlush, sendPacketWEn, sendPacketPID,
      output dataToggle, transDone, transStatus
   );

   modport master (
      output tokenRxed, tokenPID, tokenEndP, epEnable, epStall, epReady,
      output RXPacketRdy, RxPID, CRCError, bitStuffError, RXOverflow, RXTimeOut,
      output dataSequence, sendPacketRdy,
      input  getPacketEn, fifoCommit, fifoFlush, sendPacketWEn, sendPacketPID,
      input  dataToggle, transDone, transStatus
   );

endinterface

// File: rtl/slave_out_data_ctrl.sv
// Slave receive-path sequencer for host-to-device data phases (OUT, SETUP).
// Arms the packet receiver on an accepted token, evaluates the receive report
// against endpoint state and the expected data toggle, commits or flushes the
// RX FIFO, and requests the matching handshake from the packet sender.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-low reset
//   bus  - slave modport of slave_out_data_ctrl_if (all other signals)
// Parameters:
//   NUM_EP     - number of endpoints (width of per-endpoint vectors)
//   RESP_DELAY - idle cycles between evaluation and handshake request, 1..15
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for an accepted OUT/SETUP token
// ARM      | pulse getPacketEn to the packet receiver
// WAIT_RDY | waiting for the receive report (RXPacketRdy)
// EVAL     | decide commit/flush, handshake and status
// HS_DELAY | inter-packet delay before requesting the handshake
// SEND_HS  | sendPacketWEn held until the sender accepts
// DONE     | pulse transDone, publish transStatus
module slave_out_data_ctrl
   import slave_out_data_ctrl_pkg::*;
#(
   parameter int NUM_EP     = 4,
   parameter int RESP_DELAY = 3
) (
   input logic                  clk,
   input logic                  rst,
   slave_out_data_ctrl_if.slave bus
);

   localparam logic [3:0] DLY_LOAD = 4'(RESP_DELAY - 1);

   ctrlState_t        state;
   logic [1:0]        epIdx;
   logic              isSetup;
   logic [3:0]        rxPID;
   logic              rxBadCrc;
   logic              rxOverflow;
   logic              rxTimeOut;
   logic              rxDataSeq;
   logic [3:0]        dlyCnt;
   logic [5:0]        statusPend;
   logic [NUM_EP-1:0] toggleReg;

   logic              tokenOk;
   logic              tokenIsSetup;
   logic              evCommit;
   logic              evHs;
   logic [3:0]        evPID;
   logic [5:0]        evStatus;
   logic              evToggle;

   assign bus.dataToggle = toggleReg;
   assign tokenIsSetup   = (bus.tokenPID == PID_SETUP);

   // Endpoint range is checked first so the enable lookup never indexes past NUM_EP.
   assign tokenOk = bus.tokenRxed
                 && (int'(bus.tokenEndP) < NUM_EP)
                 && bus.epEnable[bus.tokenEndP]
                 && (tokenIsSetup || (bus.tokenPID == PID_OUT));

   // Ordered decision: the first matching condition decides the outcome.
   always_comb begin
      evCommit = 1'b0;
      evHs     = 1'b0;
      evPID    = PID_ACK;
      evStatus = '0;
      evToggle = 1'b0;
      if (rxTimeOut) begin
         evStatus[ST_TIMEOUT] = 1'b1;
      end else if (rxBadCrc) begin
         evStatus[ST_CRC] = 1'b1;
      end else if ((rxPID != PID_DATA0) && (rxPID != PID_DATA1)) begin
         evStatus[ST_CRC] = 1'b1;
      end else if (isSetup && rxOverflow) begin
         evStatus[ST_CRC] = 1'b1;
      end else if (!isSetup && bus.epStall[epIdx]) begin
         evHs               = 1'b1;
         evPID              = PID_STALL;
         evStatus[ST_STALL] = 1'b1;
      end else if (!isSetup && (!bus.epReady[epIdx] || rxOverflow)) begin
         evHs             = 1'b1;
         evPID            = PID_NAK;
         evStatus[ST_NAK] = 1'b1;
      end else if (rxDataSeq != toggleReg[epIdx]) begin
         // Retransmission of a packet already taken: ACK again but drop the data.
         evHs             = 1'b1;
         evStatus[ST_ACK] = 1'b1;
         evStatus[ST_DUP] = 1'b1;
      end else begin
         evCommit         = 1'b1;
         evHs             = 1'b1;
         evStatus[ST_ACK] = 1'b1;
         evToggle         = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state             <= IDLE;
         epIdx             <= '0;
         isSetup           <= 1'b0;
         rxPID             <= '0;
         rxBadCrc          <= 1'b0;
         rxOverflow        <= 1'b0;
         rxTimeOut         <= 1'b0;
         rxDataSeq         <= 1'b0;
         dlyCnt            <= '0;
         statusPend        <= '0;
         toggleReg         <= '0;
         bus.getPacketEn   <= 1'b0;
         bus.fifoCommit    <= 1'b0;
         bus.fifoFlush     <= 1'b0;
         bus.sendPacketWEn <= 1'b0;
         bus.sendPacketPID <= 4'h0;
         bus.transDone     <= 1'b0;
         bus.transStatus   <= '0;
      end else begin
         bus.getPacketEn <= 1'b0;
         bus.fifoCommit  <= 1'b0;
         bus.fifoFlush   <= 1'b0;
         bus.transDone   <= 1'b0;
         case (state)
            IDLE: begin
               if (tokenOk) begin
                  epIdx   <= bus.tokenEndP;
                  isSetup <= tokenIsSetup;
                  // SETUP always starts a control transfer at DATA0.
                  if (tokenIsSetup) toggleReg[bus.tokenEndP] <= 1'b0;
                  state <= ARM;
               end
            end
            ARM: begin
               bus.getPacketEn <= 1'b1;
               state           <= WAIT_RDY;
            end
            WAIT_RDY: begin
               if (bus.RXPacketRdy) begin
                  rxPID      <= bus.RxPID;
                  rxBadCrc   <= bus.CRCError | bus.bitStuffError;
                  rxOverflow <= bus.RXOverflow;
                  rxTimeOut  <= bus.RXTimeOut;
                  rxDataSeq  <= bus.dataSequence;
                  state      <= EVAL;
               end
            end
            EVAL: begin
               bus.fifoCommit <= evCommit;
               bus.fifoFlush  <= ~evCommit;
               if (evToggle) toggleReg[epIdx] <= ~toggleReg[epIdx];
               statusPend <= evStatus;
               dlyCnt     <= DLY_LOAD;
               if (evHs) begin
                  bus.sendPacketPID <= evPID;
                  state             <= HS_DELAY;
               end else begin
                  state <= DONE;
               end
            end
            HS_DELAY: begin
               if (dlyCnt == 4'd0) begin
                  bus.sendPacketWEn <= 1'b1;
                  state             <= SEND_HS;
               end else begin
                  dlyCnt <= dlyCnt - 4'd1;
               end
            end
            SEND_HS: begin
               if (bus.sendPacketRdy) begin
                  bus.sendPacketWEn <= 1'b0;
                  state             <= DONE;
               end
            end
            DONE: begin
               bus.transDone   <= 1'b1;
               bus.transStatus <= statusPend;
               state           <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
